// File: rtl/xnor4_bist.sv
// rtl/xnor4_bist.sv - built-in self-test sweep controller for the XNOR block
module xnor4_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [WIDTH-1:0]   dut_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_valid
);

    localparam int IW = 2 * WIDTH;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [3:0]    settle_cnt;
    logic          mismatch;
    logic          last_vec;

    // Operands come straight from the registered index, so they only move when idx does.
    assign dut_a    = idx[IW-1:WIDTH];
    assign dut_b    = idx[WIDTH-1:0];
    assign mismatch = (dut_y != ~(dut_a ^ dut_b));
    assign last_vec = &idx;

    assign busy = (state == S_DRIVE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
            S_DRIVE:        if (settle_cnt == 4'd0) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = last_vec ? S_DONE : S_DRIVE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            settle_cnt <= 4'd0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt != 4'd0)
                        settle_cnt <= settle_cnt - 4'd1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_a     <= dut_a;
                            fail_b     <= dut_b;
                            fail_valid <= 1'b1;
                        end
                    end
                    // On the last vector idx stays put so the operands hold through DONE.
                    if (!last_vec) begin
                        idx        <= idx + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xnor4_bist.sv
// tb/tb_xnor4_bist.sv - self-checking bench for xnor4_bist with fault-injecting DUT models
module tb_xnor4_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3;
    logic [3:0] a1, b1, y1, a3, b3, y3;
    logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [8:0] err1, err3;
    logic [3:0] fa1, fb1, fa3, fb3;

    logic       fault_en, fault_val, pipe_en;
    logic [1:0] fault_bit;
    logic [3:0] y1c, p1a, p1b, p3a, p3b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xnor4_bist #(.WIDTH(4), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1), .fail_valid(fv1)
    );

    xnor4_bist #(.WIDTH(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start3), .dut_a(a3), .dut_b(b3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_a(fa3), .fail_b(fb3), .fail_valid(fv3)
    );

    // DUT stand-ins: golden XNOR with optional stuck-at bit, or a two-stage pipelined XNOR.
    always_comb begin
        y1c = ~(a1 ^ b1);
        if (fault_en) y1c[fault_bit] = fault_val;
    end

    always @(posedge clk) begin
        p1a <= ~(a1 ^ b1);
        p1b <= p1a;
        p3a <= ~(a3 ^ b3);
        p3b <= p3a;
    end

    assign y1 = pipe_en ? p1b : y1c;
    assign y3 = p3b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_stuck(input int bit_i, input int val,
                                        output int errs, output int fa, output int fb);
        bit first = 1'b1;
        errs = 0; fa = 0; fb = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int good = ~(a ^ b) & 15;
                int seen = val ? (good | (1 << bit_i)) : (good & ~(1 << bit_i));
                if (good != seen) begin
                    errs++;
                    if (first) begin
                        fa = a; fb = b; first = 1'b0;
                    end
                end
            end
        end
    endfunction

    // Pulses start on the selected instance and counts busy cycles until done.
    task automatic sweep(input int sel, input bit check_ops, input int settle, output int cycles);
        if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        cycles = 0;
        while (!((sel == 1) ? done1 : done3) && cycles < 5000) begin
            if ((sel == 1) ? busy1 : busy3) begin
                if (check_ops)
                    chk("operands", 32'((sel == 1) ? {a1, b1} : {a3, b3}), 32'(cycles / (settle + 1)));
                cycles++;
            end
            @(negedge clk);
        end
        chk("sweep_reaches_done", 32'((sel == 1) ? done1 : done3), 32'd1);
    endtask

    task automatic all_zero(input string tag);
        chk(tag, 32'({a1, b1, busy1, done1, pass1, err1, fa1, fb1, fv1}), 32'd0);
        chk({tag, "_s3"}, 32'({a3, b3, busy3, done3, pass3, err3, fa3, fb3, fv3}), 32'd0);
    endtask

    initial begin
        int cyc, m_err, m_fa, m_fb, rb, rv;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        fault_en = 1'b0; fault_val = 1'b0; fault_bit = 2'd0; pipe_en = 1'b0;
        repeat (3) @(negedge clk);
        all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Golden sweep with per-vector operand checks.
        sweep(1, 1'b1, 1, cyc);
        chk("golden_busy_cycles", 32'(cyc), 32'd512);
        chk("golden_busy_low", 32'(busy1), 32'd0);
        chk("golden_pass", 32'(pass1), 32'd1);
        chk("golden_err", 32'(err1), 32'd0);
        chk("golden_fail_valid", 32'(fv1), 32'd0);
        chk("golden_hold_last", 32'({a1, b1}), 32'hff);

        // Directed stuck-at faults, then randomized ones, all against the model.
        for (int t = 0; t < 5; t++) begin
            if (t == 0) begin rb = 0; rv = 0; end
            else if (t == 1) begin rb = 3; rv = 1; end
            else begin rb = $urandom_range(0, 3); rv = $urandom_range(0, 1); end
            fault_en = 1'b1; fault_bit = 2'(rb); fault_val = rv[0];
            model_stuck(rb, rv, m_err, m_fa, m_fb);
            sweep(1, 1'b0, 1, cyc);
            chk("stuck_err_count", 32'(err1), 32'(m_err));
            chk("stuck_pass", 32'(pass1), 32'(m_err == 0));
            chk("stuck_fail_a", 32'(fa1), 32'(m_fa));
            chk("stuck_fail_b", 32'(fb1), 32'(m_fb));
            chk("stuck_fail_valid", 32'(fv1), 32'(m_err != 0));
        end
        fault_en = 1'b0;

        // Reset in the middle of a sweep, then a clean rerun.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        fault_en = 1'b1; fault_bit = 2'd0; fault_val = 1'b0;
        repeat (99) @(negedge clk);
        chk("midsweep_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        all_zero("midsweep_reset");
        rst = 1'b0;
        fault_en = 1'b0;
        @(negedge clk);
        sweep(1, 1'b0, 1, cyc);
        chk("post_reset_cycles", 32'(cyc), 32'd512);
        chk("post_reset_pass", 32'(pass1), 32'd1);

        // Start held high: no restart while busy, restart once done.
        fault_en = 1'b1; fault_bit = 2'd0; fault_val = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!done1 && cyc < 5000) begin
            if (busy1) begin
                chk("held_start_operands", 32'({a1, b1}), 32'(cyc / 2));
                cyc++;
            end
            @(negedge clk);
        end
        chk("held_start_cycles", 32'(cyc), 32'd512);
        chk("held_start_err", 32'(err1), 32'd128);
        @(negedge clk);
        chk("restart_done_low", 32'(done1), 32'd0);
        chk("restart_busy_high", 32'(busy1), 32'd1);
        chk("restart_err_clear", 32'({err1, fv1}), 32'd0);
        start1 = 1'b0;
        fault_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two-stage pipelined DUT: fine with SETTLE=3, fails with SETTLE=1.
        sweep(3, 1'b0, 3, cyc);
        chk("pipe_s3_cycles", 32'(cyc), 32'd1024);
        chk("pipe_s3_pass", 32'(pass3), 32'd1);
        pipe_en = 1'b1;
        sweep(1, 1'b0, 1, cyc);
        chk("pipe_s1_pass", 32'(pass1), 32'd0);
        chk("pipe_s1_err_nonzero", 32'(err1 > 9'd0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
